interrupt_arbiter: RTL and testbench
====================================

# interrupt_arbiter

Prioritising interrupt controller between the I/O controller's 8-bit `interrupts` vector and the CPU core. It latches rising edges on each source into a pending register, applies per-source and global enables, and presents the highest-priority request to the CPU with a 3-bit vector. It tracks the in-service source through an acknowledge/return handshake. Software configures it through a small 2-bit-address register port that decodes alongside the existing I/O register space.

## Interface
- No parameters; source count is fixed at 8, vector width at 3.
- `clk` in 1: clock; all state changes on the rising edge.
- `reset` in 1: reset, synchronous, active-high.
- `irq_in` in 8: source lines from the I/O controller; bit 0 is the highest priority.
- `cfg_addr` in 2: register select for read and write.
- `cfg_wdata` in 8: write data.
- `cfg_we` in 1: write strobe, one cycle per write.
- `cfg_rdata` out 8: registered read data for `cfg_addr`.
- `int_req` out 1: interrupt request to the CPU.
- `int_vector` out 3: index of the requested source; valid while `int_req` is high.
- `int_ack` in 1: one-cycle pulse; the CPU accepts the current `int_vector`.
- `int_done` in 1: one-cycle pulse; the CPU returns from the handler.

## Operation
- Registers:
  - 0 MASK: RW, reset 0x00; 1 enables a source.
  - 1 PEND: read gives pending bits; writing 1 clears that bit (W1C); reset 0x00.
  - 2 CTRL: bit0 is GIE, reset 0; bits 7:1 read 0 and writes to them are ignored.
  - 3 ISR: read-only in-service bits, reset 0x00; writes are ignored.
- Edge detect:
  - `irq_prev` is loaded from `irq_in` every cycle, including during reset.
  - `PEND[i]` sets when `irq_in[i] & ~irq_prev[i]`.
  - If a set and a clear (W1C or ack) hit the same bit in the same cycle, the set wins.
- Candidate:
  - `cand = PEND & MASK`, taken only when GIE=1.
  - The winner is the lowest set index.
- FSM states: IDLE, REQ, SVC.
  - IDLE → REQ when the candidate is non-zero.
  - REQ: `int_req`=1 and `int_vector`=winner, both recomputed every cycle.
    - If the candidate becomes zero (mask, W1C or GIE cleared), go to IDLE and drop `int_req`.
    - On `int_ack`: clear `PEND[int_vector]`, set `ISR[int_vector]`, go to SVC.
  - SVC: `int_req`=0. On `int_done`: clear the ISR bit, then go to REQ if the candidate is non-zero, otherwise IDLE.
- Ignored handshakes:
  - `int_ack` outside REQ is ignored.
  - `int_done` outside SVC, or with ISR=0, is ignored.
- Reset mid-operation returns to IDLE and clears all state. A handler that was in progress gets no `int_done` effect.

## Timing
- All outputs are registered. Reset values: `int_req`=0, `int_vector`=0, `cfg_rdata`=0x00.
- Rising edge on `irq_in` at cycle N: PEND is set at N+1, and `int_req` rises at N+2 (mask and GIE already set).
- `int_ack` at cycle M: `int_req`=0 and ISR updated at M+1. The vector acknowledged is the `int_vector` value presented during cycle M.
- `int_done` at cycle D with another candidate pending: `int_req` rises at D+1.
- `cfg_rdata` reflects the `cfg_addr` of cycle N at N+1. A read in the cycle after a write returns the new value.
- A write to MASK, PEND or CTRL affects the candidate in the cycle after `cfg_we`.

## Configuration
- `INTR_NESTED_EN` defined:
  - SVC also moves to REQ when the candidate winner index is less than the lowest set ISR bit.
  - ISR may hold several bits.
  - `int_done` clears the lowest set ISR bit. The FSM returns to SVC while ISR≠0 and there is no higher-priority candidate, otherwise to REQ or IDLE.
- `INTR_NESTED_EN` undefined:
  - Single level; at most one ISR bit is set.
  - No request is issued while in SVC.

## Test plan
- Sources 3 and 1 both pending in the same cycle, MASK=0xFF, GIE=1 → `int_req` with vector 1. After ack and done, `int_req` with vector 3, then IDLE with PEND=0x00.
- `irq_in[2]` high through reset and held afterwards → PEND stays 0x00 and no request is made. A low-then-high pulse afterwards → PEND=0x04.
- `int_req` pending on vector 5, software writes MASK=0x00 → `int_req` drops the next cycle and PEND reads 0x20. Rewriting MASK=0x20 restores the request.
- `int_ack` and a new rising edge on the same source in the same cycle → ISR bit set and PEND bit still 1. After `int_done`, the request is re-issued.
- Servicing source 4 and source 0 fires:
  - with `INTR_NESTED_EN` → `int_req` with vector 0 and ISR=0x11; the first `int_done` leaves ISR=0x10.
  - without it → no request until `int_done`.
- `int_ack` in IDLE and `int_done` in REQ → no state change and no register change.

Source files
------------

// File: rtl/interrupt_arbiter.sv
// Prioritising interrupt controller: edge-latched pending bits, mask/GIE gating and
// ack/done service tracking. Define INTR_NESTED_EN to allow nested (preemptive) service.
module interrupt_arbiter (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] irq_in,
    input  logic [1:0] cfg_addr,
    input  logic [7:0] cfg_wdata,
    input  logic       cfg_we,
    output logic [7:0] cfg_rdata,
    output logic       int_req,
    output logic [2:0] int_vector,
    input  logic       int_ack,
    input  logic       int_done
);

    typedef enum logic [1:0] {StIdle, StReq, StSvc} state_e;

    state_e     state_q, state_d;
    logic [7:0] irq_prev_q, mask_q, mask_d, pend_q, pend_d, isr_q, isr_d;
    logic       gie_q, gie_d;
    logic [7:0] cand, ack_clr, w1c, rdata_d;
    logic [2:0] win, vector_d;
    logic       cand_any;
`ifdef INTR_NESTED_EN
    logic [7:0] isr_rem;
    logic [3:0] isr_low, rem_low;  // 8 encodes "no bit set"
`endif

    assign cand     = gie_q ? (pend_q & mask_q) : 8'h00;
    assign cand_any = |cand;

    always_comb begin
        win = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (cand[i]) win = 3'(i);
        end
    end

`ifdef INTR_NESTED_EN
    assign isr_rem = isr_q & (isr_q - 8'd1);  // in-service set minus its lowest bit

    always_comb begin
        isr_low = 4'd8;
        rem_low = 4'd8;
        for (int i = 7; i >= 0; i--) begin
            if (isr_q[i])   isr_low = 4'(i);
            if (isr_rem[i]) rem_low = 4'(i);
        end
    end
`endif

    always_comb begin
        state_d  = state_q;
        isr_d    = isr_q;
        ack_clr  = 8'h00;
        vector_d = int_vector;
        case (state_q)
            StIdle: begin
                if (cand_any) state_d = StReq;
            end
            StReq: begin
                if (int_ack) begin
                    ack_clr = 8'd1 << int_vector;
                    isr_d   = isr_q | ack_clr;
                    state_d = StSvc;
                end else if (!cand_any) begin
`ifdef INTR_NESTED_EN
                    state_d = (isr_q != 8'h00) ? StSvc : StIdle;
`else
                    state_d = StIdle;
`endif
                end
            end
            StSvc: begin
`ifdef INTR_NESTED_EN
                if (int_done && isr_q != 8'h00) begin
                    isr_d = isr_rem;
                    if (cand_any && {1'b0, win} < rem_low) state_d = StReq;
                    else state_d = (isr_rem != 8'h00) ? StSvc : StIdle;
                end else if (cand_any && {1'b0, win} < isr_low) begin
                    state_d = StReq;
                end
`else
                if (int_done && isr_q != 8'h00) begin
                    isr_d   = 8'h00;
                    state_d = cand_any ? StReq : StIdle;
                end
`endif
            end
            default: state_d = StIdle;
        endcase
        if (state_d == StReq) vector_d = win;
    end

    // A fresh edge in the same cycle as a clear leaves the bit set.
    assign w1c    = (cfg_we && cfg_addr == 2'd1) ? cfg_wdata : 8'h00;
    assign pend_d = (pend_q & ~(w1c | ack_clr)) | (irq_in & ~irq_prev_q);
    assign mask_d = (cfg_we && cfg_addr == 2'd0) ? cfg_wdata : mask_q;
    assign gie_d  = (cfg_we && cfg_addr == 2'd2) ? cfg_wdata[0] : gie_q;

    always_comb begin
        rdata_d = 8'h00;
        case (cfg_addr)
            2'd0: rdata_d = mask_q;
            2'd1: rdata_d = pend_q;
            2'd2: rdata_d = {7'd0, gie_q};
            2'd3: rdata_d = isr_q;
            default: rdata_d = 8'h00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        irq_prev_q <= irq_in;
        if (reset) begin
            mask_q     <= 8'h00;
            pend_q     <= 8'h00;
            isr_q      <= 8'h00;
            gie_q      <= 1'b0;
            int_req    <= 1'b0;
            int_vector <= 3'd0;
            cfg_rdata  <= 8'h00;
        end else begin
            mask_q     <= mask_d;
            pend_q     <= pend_d;
            isr_q      <= isr_d;
            gie_q      <= gie_d;
            int_req    <= (state_d == StReq);
            int_vector <= vector_d;
            cfg_rdata  <= rdata_d;
        end
    end

endmodule

// File: tb/tb_interrupt_arbiter.sv
// Randomised bench for interrupt_arbiter against a queue-based reference model,
// preceded by a few directed scenarios.
module tb_interrupt_arbiter;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] irq_in;
    logic [1:0] cfg_addr;
    logic [7:0] cfg_wdata;
    logic       cfg_we;
    logic [7:0] cfg_rdata;
    logic       int_req;
    logic [2:0] int_vector;
    logic       int_ack;
    logic       int_done;

    always #5 clk = ~clk;

    interrupt_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .irq_in     (irq_in),
        .cfg_addr   (cfg_addr),
        .cfg_wdata  (cfg_wdata),
        .cfg_we     (cfg_we),
        .cfg_rdata  (cfg_rdata),
        .int_req    (int_req),
        .int_vector (int_vector),
        .int_ack    (int_ack),
        .int_done   (int_done)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: sources in service kept as a list of indices.
    bit         m_req;
    logic [2:0] m_vec;
    logic [7:0] m_pend, m_mask, m_prev, m_rdata;
    bit         m_gie;
    int         m_svc[$];

    function automatic int lowest(input logic [7:0] v);
        for (int i = 0; i < 8; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic logic [7:0] svc_bits();
        logic [7:0] b = 8'h00;
        foreach (m_svc[k]) b[m_svc[k]] = 1'b1;
        return b;
    endfunction

    function automatic int svc_min_pos();
        int pos = -1;
        foreach (m_svc[k]) if (pos < 0 || m_svc[k] < m_svc[pos]) pos = k;
        return pos;
    endfunction

    task automatic model_step();
        int best, lo, pos;
        bit can_take;
        logic [7:0] cand;
        if (reset) begin
            m_prev = irq_in;
            m_pend = 8'h00; m_mask = 8'h00; m_gie = 1'b0;
            m_req = 1'b0; m_vec = 3'd0; m_rdata = 8'h00;
            m_svc.delete();
            return;
        end
        case (cfg_addr)
            2'd0: m_rdata = m_mask;
            2'd1: m_rdata = m_pend;
            2'd2: m_rdata = {7'd0, m_gie};
            default: m_rdata = svc_bits();
        endcase
        cand = m_gie ? (m_pend & m_mask) : 8'h00;
        best = lowest(cand);
        if (m_req) begin
            if (int_ack) begin
                m_pend[m_vec] = 1'b0;
                m_svc.push_back(int'(m_vec));
                m_req = 1'b0;
            end else if (best < 0) begin
                m_req = 1'b0;
            end else begin
                m_vec = 3'(best);
            end
        end else if (m_svc.size() == 0) begin
            if (best >= 0) begin m_req = 1'b1; m_vec = 3'(best); end
        end else begin
            if (int_done) m_svc.delete(svc_min_pos());
            pos = svc_min_pos();
            lo = (pos < 0) ? 8 : m_svc[pos];
`ifdef INTR_NESTED_EN
            can_take = 1'b1;
`else
            can_take = int_done;
`endif
            if (can_take && best >= 0 && best < lo) begin m_req = 1'b1; m_vec = 3'(best); end
        end
        if (cfg_we) begin
            case (cfg_addr)
                2'd0: m_mask = cfg_wdata;
                2'd1: m_pend = m_pend & ~cfg_wdata;
                2'd2: m_gie = cfg_wdata[0];
                default: ;
            endcase
        end
        m_pend = m_pend | (irq_in & ~m_prev);
        m_prev = irq_in;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check("int_req", 8'(int_req), 8'(m_req));
        check("int_vector", 8'(int_vector), 8'(m_vec));
        check("cfg_rdata", cfg_rdata, m_rdata);
        cfg_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [7:0] d);
        cfg_addr = a; cfg_wdata = d; cfg_we = 1'b1;
        tick();
    endtask

    task automatic rd_expect(input string tag, input logic [1:0] a, input logic [7:0] exp);
        cfg_addr = a;
        tick();
        check(tag, cfg_rdata, exp);
    endtask

    initial begin
        reset = 1'b1; irq_in = 8'h04; cfg_addr = 2'd0; cfg_wdata = 8'h00;
        cfg_we = 1'b0; int_ack = 1'b0; int_done = 1'b0;
        repeat (3) tick();
        check("rst_req", 8'(int_req), 8'h00);
        check("rst_vec", 8'(int_vector), 8'h00);
        check("rst_rdata", cfg_rdata, 8'h00);
        reset = 1'b0;

        // Line held high through reset gives no edge; a later pulse does.
        wr(2'd0, 8'hFF);
        wr(2'd2, 8'h01);
        tick(); tick();
        rd_expect("held_pend", 2'd1, 8'h00);
        check("held_req", 8'(int_req), 8'h00);
        irq_in = 8'h00; tick();
        irq_in = 8'h04; tick(); tick();
        rd_expect("pulse_pend", 2'd1, 8'h04);
        int_ack = 1'b1; tick();
        int_done = 1'b1; tick();
        irq_in = 8'h00; tick();

        // Sources 3 and 1 together: 1 first, then 3.
        irq_in = 8'h0A; tick(); tick();
        check("s1_req", 8'(int_req), 8'h01);
        check("s1_vec", 8'(int_vector), 8'd1);
        int_ack = 1'b1; tick();
        check("s1_ack_req", 8'(int_req), 8'h00);
        int_done = 1'b1; tick();
        check("s1_done_req", 8'(int_req), 8'h01);
        check("s1_vec3", 8'(int_vector), 8'd3);
        int_ack = 1'b1; tick();
        int_done = 1'b1; tick();
        check("s1_idle_req", 8'(int_req), 8'h00);
        rd_expect("s1_pend", 2'd1, 8'h00);
        irq_in = 8'h00; tick();

        // Masking a live request drops it; unmasking restores it.
        irq_in = 8'h20; tick(); tick();
        check("m_vec5", 8'(int_vector), 8'd5);
        wr(2'd0, 8'h00);
        tick();
        check("m_drop", 8'(int_req), 8'h00);
        rd_expect("m_pend", 2'd1, 8'h20);
        irq_in = 8'h00;
        wr(2'd0, 8'h20);
        tick();
        check("m_restore", 8'(int_req), 8'h01);

        // Ack coinciding with a new edge on the same source.
        int_ack = 1'b1; irq_in = 8'h20; tick();
        rd_expect("ae_isr", 2'd3, 8'h20);
        rd_expect("ae_pend", 2'd1, 8'h20);
        int_done = 1'b1; tick();
        check("ae_rereq", 8'(int_req), 8'h01);
        int_ack = 1'b1; tick();
        int_done = 1'b1; tick();
        wr(2'd0, 8'hFF);
        irq_in = 8'h00; tick();

        // Source 0 fires while source 4 is in service.
        irq_in = 8'h10; tick(); tick();
        int_ack = 1'b1; tick();
        irq_in = 8'h11; tick(); tick();
`ifdef INTR_NESTED_EN
        check("nest_req", 8'(int_req), 8'h01);
        check("nest_vec", 8'(int_vector), 8'd0);
        int_ack = 1'b1; tick();
        rd_expect("nest_isr", 2'd3, 8'h11);
        int_done = 1'b1; tick();
        rd_expect("nest_isr_done", 2'd3, 8'h10);
        int_done = 1'b1; tick();
`else
        check("flat_noreq", 8'(int_req), 8'h00);
        int_done = 1'b1; tick();
        check("flat_req", 8'(int_req), 8'h01);
        check("flat_vec", 8'(int_vector), 8'd0);
        int_ack = 1'b1; tick();
        int_done = 1'b1; tick();
`endif
        irq_in = 8'h00; tick(); tick();

        // Stray ack in IDLE and stray done in REQ.
        int_ack = 1'b1; tick();
        rd_expect("stray_isr", 2'd3, 8'h00);
        irq_in = 8'h40; tick(); tick();
        int_done = 1'b1; tick();
        check("stray_req", 8'(int_req), 8'h01);
        check("stray_vec", 8'(int_vector), 8'd6);
        rd_expect("stray_isr2", 2'd3, 8'h00);

        for (int c = 0; c < 4000; c++) begin
            if ($urandom_range(0, 3) == 0) irq_in = irq_in ^ (8'd1 << $urandom_range(0, 7));
            reset = ($urandom_range(0, 599) == 0);
            cfg_addr = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                cfg_we = 1'b1;
                cfg_wdata = 8'($urandom);
                if (cfg_addr == 2'd0 && $urandom_range(0, 1) == 0) cfg_wdata = 8'hFF;
                if (cfg_addr == 2'd2 && $urandom_range(0, 3) != 0) cfg_wdata[0] = 1'b1;
            end
            int_ack = m_req ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 15) == 0);
            int_done = (m_svc.size() != 0) ? ($urandom_range(0, 5) == 0)
                                           : ($urandom_range(0, 15) == 0);
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
